// File: rtl/picorv_axil_mem_mmio.sv
// AXI4-Lite slave behind the picorv32_axi memory port. It provides a word RAM,
// byte-wide output channels with one-cycle strobes, a level trigger register,
// and a programmable read latency for bus-timing experiments.
module picorv_axil_mem_mmio #(
    parameter int          MEM_WORDS     = 4096,
    parameter string       MEM_INIT_FILE = "firmware.hex",
    parameter int          OUT_CHANNELS  = 1,
    parameter logic [31:0] OUT_BASE      = 32'h1000_0000,
    parameter logic [31:0] TRIG_ADDR     = 32'h1000_0100,
    parameter int          READ_WAIT     = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mem_axi_awvalid,
    output logic                      mem_axi_awready,
    input  logic [31:0]               mem_axi_awaddr,
    input  logic [2:0]                mem_axi_awprot,
    input  logic                      mem_axi_wvalid,
    output logic                      mem_axi_wready,
    input  logic [31:0]               mem_axi_wdata,
    input  logic [3:0]                mem_axi_wstrb,
    output logic                      mem_axi_bvalid,
    input  logic                      mem_axi_bready,
    input  logic                      mem_axi_arvalid,
    output logic                      mem_axi_arready,
    input  logic [31:0]               mem_axi_araddr,
    input  logic [2:0]                mem_axi_arprot,
    output logic                      mem_axi_rvalid,
    input  logic                      mem_axi_rready,
    output logic [31:0]               mem_axi_rdata,
    output logic [8*OUT_CHANNELS-1:0] out_byte,
    output logic [OUT_CHANNELS-1:0]   out_byte_en,
    output logic                      trigger,
    output logic                      err_unmapped
);

    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [1:0] W_IDLE   = 2'd0;
    localparam logic [1:0] W_COMMIT = 2'd1;
    localparam logic [1:0] W_RESP   = 2'd2;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    genvar gi;

    logic [31:0] mem [0:MEM_WORDS-1];

    // Write channel state
    logic [1:0]  w_state_reg;
    logic        aw_held_reg, w_held_reg;
    logic [31:2] awaddr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wstrb_reg;
    logic        aw_hs, w_hs, commit;

    // Read channel state
    logic [1:0]  r_state_reg;
    logic [31:2] araddr_reg;
    logic [2:0]  wait_cnt_reg;
    logic        rvalid_reg, rd_sel_ram_reg, rd_sample;
    logic [31:0] ram_q_reg, reg_q_reg, rd_reg_data;

    // Address decode for both channels
    logic                    wr_ram_hit, wr_trig_hit, wr_unmapped;
    logic                    rd_ram_hit, rd_trig_hit, rd_unmapped;
    logic [OUT_CHANNELS-1:0] wr_chan_hit, rd_chan_hit;

    logic trigger_reg, err_reg;
    logic unused_inputs;

    // Address low bits and protection are irrelevant to a word-addressed target.
    assign unused_inputs = ^{mem_axi_awprot, mem_axi_arprot, mem_axi_awaddr[1:0], mem_axi_araddr[1:0]};

    assign mem_axi_awready = (w_state_reg == W_IDLE) && !aw_held_reg;
    assign mem_axi_wready  = (w_state_reg == W_IDLE) && !w_held_reg;
    assign mem_axi_bvalid  = (w_state_reg == W_RESP);
    assign aw_hs  = mem_axi_awvalid && mem_axi_awready;
    assign w_hs   = mem_axi_wvalid && mem_axi_wready;
    assign commit = (w_state_reg == W_COMMIT);

    assign wr_ram_hit  = (awaddr_reg[31:AW+2] == '0);
    assign wr_trig_hit = (awaddr_reg == TRIG_ADDR[31:2]);
    assign wr_unmapped = !(wr_ram_hit || (|wr_chan_hit) || wr_trig_hit);

    assign rd_ram_hit  = (araddr_reg[31:AW+2] == '0);
    assign rd_trig_hit = (araddr_reg == TRIG_ADDR[31:2]);
    assign rd_unmapped = !(rd_ram_hit || (|rd_chan_hit) || rd_trig_hit);

    // Write FSM: collect AW and W in any order, commit for one cycle, then respond.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_reg <= W_IDLE;
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    if (aw_hs) begin
                        awaddr_reg  <= mem_axi_awaddr[31:2];
                        aw_held_reg <= 1'b1;
                    end
                    if (w_hs) begin
                        wdata_reg  <= mem_axi_wdata;
                        wstrb_reg  <= mem_axi_wstrb;
                        w_held_reg <= 1'b1;
                    end
                    if ((aw_held_reg || aw_hs) && (w_held_reg || w_hs))
                        w_state_reg <= W_COMMIT;
                end
                W_COMMIT: begin
                    aw_held_reg <= 1'b0;
                    w_held_reg  <= 1'b0;
                    w_state_reg <= W_RESP;
                end
                W_RESP: begin
                    if (mem_axi_bready)
                        w_state_reg <= W_IDLE;
                end
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end

    // Block RAM: byte-lane writes on commit, registered read; a same-cycle read sees old data.
    always_ff @(posedge clk) begin
        if (commit && wr_ram_hit && !reset) begin
            for (int i = 0; i < 4; i++)
                if (wstrb_reg[i])
                    mem[awaddr_reg[AW+1:2]][i*8 +: 8] <= wdata_reg[i*8 +: 8];
        end
        if (rd_sample)
            ram_q_reg <= mem[araddr_reg[AW+1:2]];
    end

    generate
        for (gi = 0; gi < OUT_CHANNELS; gi++) begin : g_chan
            localparam logic [29:0] CHAN_WORD = OUT_BASE[31:2] + 30'(gi);
            logic [7:0] byte_reg;
            logic       en_reg;

            assign wr_chan_hit[gi] = (awaddr_reg == CHAN_WORD);
            assign rd_chan_hit[gi] = (araddr_reg == CHAN_WORD);

            // Byte and strobe update together so the strobe always accompanies fresh data.
            always_ff @(posedge clk) begin
                if (reset) begin
                    byte_reg <= 8'h00;
                    en_reg   <= 1'b0;
                end else begin
                    en_reg <= commit && wr_chan_hit[gi] && wstrb_reg[0];
                    if (commit && wr_chan_hit[gi] && wstrb_reg[0])
                        byte_reg <= wdata_reg[7:0];
                end
            end

            assign out_byte[gi*8 +: 8] = byte_reg;
            assign out_byte_en[gi]     = en_reg;
        end
    endgenerate

    // Trigger level and the sticky unmapped-access flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            trigger_reg <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            if (commit && wr_trig_hit && wstrb_reg[0])
                trigger_reg <= wdata_reg[0];
            if ((commit && wr_unmapped) || (rd_sample && rd_unmapped))
                err_reg <= 1'b1;
        end
    end

    assign trigger      = trigger_reg;
    assign err_unmapped = err_reg;

    // Register-space read mux; unmapped addresses read as zero.
    always_comb begin
        rd_reg_data = 32'h0;
        if (rd_trig_hit)
            rd_reg_data = {31'h0, trigger_reg};
        for (int k = 0; k < OUT_CHANNELS; k++)
            if (rd_chan_hit[k])
                rd_reg_data = {24'h0, out_byte[k*8 +: 8]};
    end

    // The first R_DATA cycle samples the target; rvalid follows one cycle later.
    assign rd_sample = (r_state_reg == R_DATA) && !rvalid_reg;

    // Read FSM: accept address, burn READ_WAIT cycles, sample, then hold data until rready.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_reg  <= R_IDLE;
            rvalid_reg   <= 1'b0;
            wait_cnt_reg <= 3'd0;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (mem_axi_arvalid) begin
                        araddr_reg   <= mem_axi_araddr[31:2];
                        wait_cnt_reg <= 3'(READ_WAIT);
                        r_state_reg  <= (READ_WAIT > 0) ? R_WAIT : R_DATA;
                    end
                end
                R_WAIT: begin
                    if (wait_cnt_reg <= 3'd1)
                        r_state_reg <= R_DATA;
                    else
                        wait_cnt_reg <= wait_cnt_reg - 3'd1;
                end
                R_DATA: begin
                    if (!rvalid_reg) begin
                        rvalid_reg     <= 1'b1;
                        rd_sel_ram_reg <= rd_ram_hit;
                        reg_q_reg      <= rd_reg_data;
                    end else if (mem_axi_rready) begin
                        rvalid_reg  <= 1'b0;
                        r_state_reg <= R_IDLE;
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

    assign mem_axi_arready = (r_state_reg == R_IDLE);
    assign mem_axi_rvalid  = rvalid_reg;
    assign mem_axi_rdata   = rvalid_reg ? (rd_sel_ram_reg ? ram_q_reg : reg_q_reg) : 32'h0;

endmodule
